// File: rtl/riscv_pkg.sv
// Shared state encoding, access-size codes and captured-request layout for the load/store unit.
package riscv_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side (riscv_lsu_if) and data-memory-side (riscv_dmem_if) bundles of the load/store unit.
interface riscv_lsu_if;
  logic        lsu_valid;
  logic        lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misaligned;
  logic        lsu_bus_err;

  modport master (output lsu_valid, lsu_we, lsu_size, lsu_addr, lsu_wdata,
                  input  lsu_stall, lsu_done, lsu_rdata, lsu_misaligned, lsu_bus_err);
  modport slave  (input  lsu_valid, lsu_we, lsu_size, lsu_addr, lsu_wdata,
                  output lsu_stall, lsu_done, lsu_rdata, lsu_misaligned, lsu_bus_err);
endinterface

interface riscv_dmem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
                  input  dmem_gnt, dmem_rvalid, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
                  output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: byte enables, store replication, load extract/extend, misalign/illegal flag.
// Purely combinational, zero latency; no flow control.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        bad
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rdata[7:0];
    case (offset)
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      2'd3:    rbyte = rdata[31:24];
      default: rbyte = rdata[7:0];
    endcase
    rhalf = offset[1] ? rdata[31:16] : rdata[15:0];

    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    bad       = 1'b0;
    case (size)
      MEM_B, MEM_BU: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{(size == MEM_B) & rbyte[7]}}, rbyte};
      end
      MEM_H, MEM_HU: begin
        bad       = offset[0];
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{(size == MEM_H) & rhalf[15]}}, rhalf};
      end
      MEM_W:   bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one data-memory transaction per op; stores finish on gnt, loads on rvalid.
// Core is stalled until done/misaligned/bus_err; each REQ/RESP phase is bounded by TIMEOUT_CYCLES.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  riscv_lsu_if.slave   core,
  riscv_dmem_if.master dmem
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t    state, state_nxt;
  lsu_req_t      cap;
  logic [CW-1:0] cnt;
  logic          accept, timeout, bad, done, misaligned, bus_err, req;
  logic [2:0]    sel_size;
  logic [1:0]    sel_off;
  logic [3:0]    be;
  logic [31:0]   wdata_rep, rdata_ext;

  // In IDLE the aligner checks the live request; afterwards it works on the captured one.
  assign sel_size = (state == IDLE) ? core.lsu_size      : cap.size;
  assign sel_off  = (state == IDLE) ? core.lsu_addr[1:0] : cap.addr[1:0];

  riscv_lsu_align u_align (
    .size      (sel_size),
    .offset    (sel_off),
    .wdata     (cap.wdata),
    .rdata     (dmem.dmem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .bad       (bad)
  );

  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap <= '{we: core.lsu_we, size: core.lsu_size, addr: core.lsu_addr, wdata: core.lsu_wdata};
      end
      // Cleared on every phase change, so REQ and RESP each get the full budget.
      cnt <= (state_nxt != state) ? '0 : cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    req        = 1'b0;
    case (state)
      IDLE: begin
        if (core.lsu_valid && !rst) begin
          if (bad) begin
            misaligned = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (dmem.dmem_gnt) begin
          done      = cap.we;
          state_nxt = cap.we ? IDLE : RESP;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: begin
        if (dmem.dmem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign core.lsu_done       = done;
  assign core.lsu_misaligned = misaligned;
  assign core.lsu_bus_err    = bus_err;
  assign core.lsu_rdata      = rdata_ext;
  assign core.lsu_stall      = core.lsu_valid & ~done & ~misaligned & ~bus_err;

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = cap.we;
  assign dmem.dmem_be    = be;
  assign dmem.dmem_addr  = {cap.addr[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata_rep;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: expected completions are queued at issue and popped when the DUT reports an event.
module tb_riscv_lsu;
  import riscv_pkg::*;

  typedef struct packed {
    logic [2:0]  kind;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  localparam logic [2:0] K_DONE = 3'b100;
  localparam logic [2:0] K_MIS  = 3'b010;
  localparam logic [2:0] K_ERR  = 3'b001;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  riscv_lsu_if  core_if ();
  riscv_dmem_if dmem_if ();

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_if),
    .dmem (dmem_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Sample point; any completion/exception event must match the head of the scoreboard.
  task automatic smp();
    exp_t       e;
    logic [2:0] ev;
    @(negedge clk);
    ev = {core_if.lsu_done, core_if.lsu_misaligned, core_if.lsu_bus_err};
    if (ev != 3'b000) begin
      if (sb.size() == 0) begin
        check("spurious_event", 32'(ev), 32'd0);
      end else begin
        e = sb.pop_front();
        check("event_kind", 32'(ev), 32'(e.kind));
        if (e.chk_rd) check("load_rdata", core_if.lsu_rdata, e.rdata);
      end
    end
  endtask

  task automatic drive_op(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    core_if.lsu_valid = 1'b1;
    core_if.lsu_we    = we;
    core_if.lsu_size  = sz;
    core_if.lsu_addr  = a;
    core_if.lsu_wdata = wd;
  endtask

  task automatic run_store(input string tag, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eaddr, input int dly);
    nxt();
    drive_op(1'b1, sz, a, wd);
    sb.push_back('{kind: K_DONE, chk_rd: 1'b0, rdata: 32'h0});
    smp();
    check({tag, "_idle_stall"}, core_if.lsu_stall, 1);
    check({tag, "_idle_req"}, dmem_if.dmem_req, 0);
    for (int i = 0; i <= dly; i++) begin
      nxt();
      dmem_if.dmem_gnt = (i == dly);
      smp();
      check({tag, "_req"}, dmem_if.dmem_req, 1);
      check({tag, "_we"}, dmem_if.dmem_we, 1);
      check({tag, "_be"}, dmem_if.dmem_be, ebe);
      check({tag, "_addr"}, dmem_if.dmem_addr, eaddr);
      check({tag, "_wdata"}, dmem_if.dmem_wdata, ewd);
      check({tag, "_stall"}, core_if.lsu_stall, (i == dly) ? 0 : 1);
    end
    nxt();
    core_if.lsu_valid = 1'b0;
    dmem_if.dmem_gnt  = 1'b0;
    smp();
    check({tag, "_after_req"}, dmem_if.dmem_req, 0);
    check({tag, "_after_stall"}, core_if.lsu_stall, 0);
  endtask

  task automatic run_load(input string tag, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd,
                          input logic [31:0] erd, input logic [3:0] ebe, input logic [31:0] eaddr, input int dly);
    nxt();
    drive_op(1'b0, sz, a, 32'h0);
    sb.push_back('{kind: K_DONE, chk_rd: 1'b1, rdata: erd});
    smp();
    for (int i = 0; i <= dly; i++) begin
      nxt();
      dmem_if.dmem_gnt = (i == dly);
      smp();
      check({tag, "_req"}, dmem_if.dmem_req, 1);
      check({tag, "_we"}, dmem_if.dmem_we, 0);
      check({tag, "_be"}, dmem_if.dmem_be, ebe);
      check({tag, "_addr"}, dmem_if.dmem_addr, eaddr);
      check({tag, "_stall"}, core_if.lsu_stall, 1);
    end
    nxt();
    dmem_if.dmem_gnt    = 1'b0;
    dmem_if.dmem_rvalid = 1'b1;
    dmem_if.dmem_rdata  = rd;
    smp();
    check({tag, "_resp_req"}, dmem_if.dmem_req, 0);
    check({tag, "_resp_stall"}, core_if.lsu_stall, 0);
    nxt();
    core_if.lsu_valid   = 1'b0;
    dmem_if.dmem_rvalid = 1'b0;
    smp();
    check({tag, "_after_req"}, dmem_if.dmem_req, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive_op(1'b0, 3'b111, 32'h0, 32'h0);
    dmem_if.dmem_gnt    = 1'b0;
    dmem_if.dmem_rvalid = 1'b0;
    dmem_if.dmem_rdata  = 32'h0;
    #2;
    check("rst_req", dmem_if.dmem_req, 0);
    check("rst_done", core_if.lsu_done, 0);
    check("rst_misaligned", core_if.lsu_misaligned, 0);
    check("rst_bus_err", core_if.lsu_bus_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    core_if.lsu_valid = 1'b0;
    rst = 1'b0;

    // Stores: delayed grant, halfword lane, byte lane.
    run_store("sw", MEM_W, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h100, 2);
    run_store("sh", MEM_H, 32'h102, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 32'h100, 0);
    run_store("sb", MEM_B, 32'h001, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 32'h000, 0);

    // Loads with sign/zero extension.
    run_load("lb",  MEM_B,  32'h203, 32'h80FF0000, 32'hFFFFFF80, 4'b1000, 32'h200, 0);
    run_load("lbu", MEM_BU, 32'h203, 32'h80FF0000, 32'h00000080, 4'b1000, 32'h200, 0);
    run_load("lhu", MEM_HU, 32'h002, 32'h80017FFF, 32'h00008001, 4'b1100, 32'h000, 0);

    // Misaligned word and illegal size, with stray gnt/rvalid that must be ignored in IDLE.
    nxt();
    drive_op(1'b0, MEM_W, 32'h101, 32'h0);
    sb.push_back('{kind: K_MIS, chk_rd: 1'b0, rdata: 32'h0});
    dmem_if.dmem_gnt    = 1'b1;
    dmem_if.dmem_rvalid = 1'b1;
    smp();
    check("lw_mis_flag", core_if.lsu_misaligned, 1);
    check("lw_mis_req", dmem_if.dmem_req, 0);
    check("lw_mis_stall", core_if.lsu_stall, 0);
    nxt();
    core_if.lsu_valid = 1'b0;
    smp();
    check("lw_mis_idle_req", dmem_if.dmem_req, 0);
    nxt();
    drive_op(1'b1, 3'b011, 32'h100, 32'h0);
    sb.push_back('{kind: K_MIS, chk_rd: 1'b0, rdata: 32'h0});
    smp();
    check("illegal_size_flag", core_if.lsu_misaligned, 1);
    nxt();
    core_if.lsu_valid   = 1'b0;
    dmem_if.dmem_gnt    = 1'b0;
    dmem_if.dmem_rvalid = 1'b0;
    smp();
    check("illegal_idle_req", dmem_if.dmem_req, 0);

    // Grant never comes: bus error in the fourth REQ cycle, then a fresh op is accepted.
    nxt();
    drive_op(1'b0, MEM_H, 32'h002, 32'h0);
    sb.push_back('{kind: K_ERR, chk_rd: 1'b0, rdata: 32'h0});
    smp();
    for (int i = 1; i <= 4; i++) begin
      nxt();
      smp();
      check("to_req", dmem_if.dmem_req, 1);
      check("to_bus_err", core_if.lsu_bus_err, (i == 4) ? 1 : 0);
    end
    run_load("to_next", MEM_W, 32'h300, 32'h12345678, 32'h12345678, 4'b1111, 32'h300, 0);

    // Grant in the same cycle the timeout would fire wins.
    run_load("prio_lh", MEM_H, 32'h002, 32'h80017FFF, 32'hFFFF8001, 4'b1100, 32'h000, 3);

    // Reset while waiting in RESP; the late rvalid must not complete anything.
    nxt();
    drive_op(1'b0, MEM_W, 32'h400, 32'h0);
    smp();
    nxt();
    dmem_if.dmem_gnt = 1'b1;
    smp();
    check("rr_req", dmem_if.dmem_req, 1);
    nxt();
    dmem_if.dmem_gnt = 1'b0;
    smp();
    check("rr_resp_req", dmem_if.dmem_req, 0);
    #2;
    rst = 1'b1;
    core_if.lsu_valid = 1'b0;
    #1;
    check("rr_rst_req", dmem_if.dmem_req, 0);
    check("rr_rst_done", core_if.lsu_done, 0);
    check("rr_rst_bus_err", core_if.lsu_bus_err, 0);
    dmem_if.dmem_rvalid = 1'b1;
    dmem_if.dmem_rdata  = 32'hCAFEF00D;
    nxt();
    smp();
    check("rr_rst_rvalid_done", core_if.lsu_done, 0);
    #2;
    rst = 1'b0;
    nxt();
    smp();
    check("rr_late_rvalid_done", core_if.lsu_done, 0);
    check("rr_late_rvalid_req", dmem_if.dmem_req, 0);
    nxt();
    dmem_if.dmem_rvalid = 1'b0;
    smp();
    run_store("rr_sb", MEM_B, 32'h003, 32'h0000005A, 4'b1000, 32'h5A5A5A5A, 32'h000, 1);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles spent in REQ or RESP before a bus error is raised.
REQ-002 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port lsu_valid, input, 1 bit: core presents a memory op (mem_read or mem_write from ctrl_signals_t).
REQ-005 Port lsu_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 Port lsu_size, input, 3 bits: funct3 encoding (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 Port lsu_addr, input, 32 bits: byte address (ALU result).
REQ-008 Port lsu_wdata, input, 32 bits: store data (rs2).
REQ-009 Port lsu_stall, output, 1 bit: core must hold its PC and inputs stable while this is high.
REQ-010 Port lsu_done, output, 1 bit: op completes this cycle.
REQ-011 Port lsu_rdata, output, 32 bits: extended load data, valid when lsu_done is high and the op is a load.
REQ-012 Port lsu_misaligned, output, 1 bit: misaligned or illegal-size exception pulse.
REQ-013 Port lsu_bus_err, output, 1 bit: timeout pulse.
REQ-014 Memory-side ports: dmem_req (output, 1), dmem_we (output, 1), dmem_be (output, 4), dmem_addr (output, 32), dmem_wdata (output, 32), dmem_gnt (input, 1), dmem_rvalid (input, 1), dmem_rdata (input, 32).

Function
REQ-015 FSM states IDLE, REQ, RESP; the state register and the captured request fields are the only sequential elements besides the timeout counter.
REQ-016 IDLE, lsu_valid high, op legal and aligned: capture we, size, addr, and wdata at the edge and go to REQ; dmem_req rises the following cycle.
REQ-017 Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0; sizes 011, 110 and 111 are illegal.
REQ-018 A misaligned or illegal op in IDLE asserts lsu_misaligned combinationally in that cycle, issues no memory request, and leaves the state in IDLE.
REQ-019 REQ: dmem_req=1 and all dmem_* outputs are driven from the captured fields and held stable until dmem_gnt is sampled high.
REQ-020 REQ with dmem_gnt high on a store: lsu_done=1 that cycle, next state IDLE.
REQ-021 REQ with dmem_gnt high on a load: next state RESP, lsu_done=0.
REQ-022 RESP: dmem_req=0; with dmem_rvalid high, lsu_done=1 and lsu_rdata reflect dmem_rdata combinationally that cycle, next state IDLE.
REQ-023 dmem_rvalid outside RESP is ignored; dmem_gnt outside REQ is ignored.
REQ-024 dmem_addr = {addr[31:2], 2'b00}.
REQ-025 Byte enables: B → 4'b0001 << addr[1:0]; H → 4'b0011 << addr[1:0]; W → 4'b1111.
REQ-026 dmem_be is driven for loads too; dmem_we mirrors the captured we.
REQ-027 Store data: B replicates wdata[7:0] ×4; H replicates wdata[15:0] ×2; W passes through.
REQ-028 Load extraction selects the byte or halfword by addr[1:0]; B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-029 lsu_stall = lsu_valid & ~lsu_done & ~lsu_misaligned & ~lsu_bus_err, so the core advances on the completion edge.
REQ-030 No op is re-accepted on that edge, because the state is leaving REQ or RESP.
REQ-031 Timeout counter: cleared on entry to REQ; increments each cycle in REQ or RESP; reaching TIMEOUT_CYCLES without gnt or rvalid pulses lsu_bus_err for 1 cycle and returns to IDLE.
REQ-032 A gnt or rvalid arriving in the same cycle as the timeout takes priority, so the op completes normally.
REQ-033 lsu_done, lsu_misaligned and lsu_bus_err are mutually exclusive in every cycle.

Reset
REQ-034 rst high: state=IDLE, counter=0, captured fields=0, immediately and independently of clk.
REQ-035 During reset, dmem_req, lsu_done, lsu_misaligned and lsu_bus_err are all 0.
REQ-036 Reset mid-REQ or mid-RESP abandons the transaction; a late rvalid after reset is ignored.

Structure
REQ-037 The following belong in riscv_pkg:
- lsu_state_t enum {IDLE, REQ, RESP};
- mem_size constants MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_BU=3'b100, MEM_HU=3'b101.
REQ-038 Exactly one combinational sub-module, riscv_lsu_align, computes byte enables, store replication, load extraction and extension, and the misalign/illegal flag.

Verification
REQ-039 Scenario 1: SW addr=0x100, wdata=0xDEADBEEF, gnt delayed 2 cycles → dmem_req held 3 cycles, be=1111, done on the gnt cycle, stall low afterwards.
REQ-040 Scenario 2: LB addr=0x203, rdata=0x80FF_0000, rvalid 1 cycle after gnt → lsu_rdata=0xFFFFFF80; the same with LBU → 0x00000080.
REQ-041 Scenario 3: SH addr=0x102, wdata=0x1234ABCD → be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x100.
REQ-042 Scenario 4: LW addr=0x101 → lsu_misaligned=1 in the same cycle, dmem_req never rises, state stays IDLE.
REQ-043 Scenario 5: LH with no gnt, TIMEOUT_CYCLES=4 → lsu_bus_err pulse after 4 REQ cycles, then a new op is accepted.
REQ-044 Scenario 6: rst asserted during RESP, then rvalid arrives → outputs zero immediately, no lsu_done, FSM in IDLE.
